// File: rtl/sfp_stream_frame_mux.sv
// Transmit-side GBT/SFP frame builder: packs {sc, motor, mem} per frame strobe.
// Motor words are paged across frames; memory words are queued; the SC word is serialised.
module sfp_stream_frame_mux #(
  parameter int unsigned SC_W      = 4,
  parameter int unsigned MOT_W     = 16,
  parameter int unsigned SLOTS     = 4,
  parameter int unsigned N_MOT     = 16,
  parameter int unsigned MEM_W     = 16,
  parameter int unsigned MEM_DEPTH = 8,
  parameter int unsigned SC_LEN    = 32,
  parameter logic [MEM_W-1:0] MEM_IDLE = '0,
  localparam int unsigned PAGES = N_MOT / SLOTS,
  localparam int unsigned PW    = (PAGES > 1) ? $clog2(PAGES) : 1,
  localparam int unsigned FW    = SC_W + SLOTS * MOT_W + MEM_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     frame_en_i,
  input  logic [N_MOT*MOT_W-1:0]   motor_i,
  input  logic [MEM_W-1:0]         mem_data_i,
  input  logic                     mem_valid_i,
  output logic                     mem_ready_o,
  input  logic [SC_LEN-1:0]        sc_word_i,
  input  logic                     sc_load_i,
  output logic                     sc_busy_o,
  output logic [FW-1:0]            frame_o,
  output logic                     frame_valid_o,
  output logic [PW-1:0]            page_o
);

  localparam int unsigned AW     = $clog2(MEM_DEPTH);
  localparam int unsigned CW     = AW + 1;
  localparam int unsigned CHUNKS = SC_LEN / SC_W;
  localparam int unsigned KW     = $clog2(CHUNKS + 1);

  typedef enum logic [0:0] {StIdle, StShift} sc_state_e;

  // Paging and motor snapshot
  logic [PW-1:0]            page_q, page_d;
  logic [N_MOT*MOT_W-1:0]   snap_q, snap_d;
  logic [SLOTS*MOT_W-1:0]   mot_field;

  always_comb begin
    mot_field = '0;
    for (int s = 0; s < SLOTS; s++) begin
      // Page 0 reads live inputs so the sweep matches the snapshot taken in the same cycle.
      if (page_q == '0) begin
        mot_field[s*MOT_W +: MOT_W] = motor_i[s*MOT_W +: MOT_W];
      end else begin
        mot_field[s*MOT_W +: MOT_W] =
          snap_q[(32'(page_q) * SLOTS + 32'(s)) * MOT_W +: MOT_W];
      end
    end
  end

  always_comb begin
    page_d = page_q;
    snap_d = snap_q;
    if (frame_en_i) begin
      if (page_q == '0) snap_d = motor_i;
      page_d = (page_q == PW'(PAGES - 1)) ? '0 : page_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      page_q <= '0;
      snap_q <= '0;
    end else begin
      page_q <= page_d;
      snap_q <= snap_d;
    end
  end

  // Memory FIFO
  logic [MEM_W-1:0] fifo_mem [MEM_DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             full, empty, push, pop;
  logic [MEM_W-1:0] mem_field;

  assign full        = (count_q == CW'(MEM_DEPTH));
  assign empty       = (count_q == '0);
  assign mem_ready_o = !reset && !full;
  assign push        = mem_valid_i && mem_ready_o;
  // Pop decision uses the pre-push count, so a word pushed into an empty FIFO waits a frame.
  assign pop         = frame_en_i && !empty;
  assign mem_field   = empty ? MEM_IDLE : fifo_mem[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= mem_data_i;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // SC serialiser
  sc_state_e         sc_state_q, sc_state_d;
  logic [SC_LEN-1:0] sc_sr_q, sc_sr_d;
  logic [KW-1:0]     sc_cnt_q, sc_cnt_d;
  logic [SC_W-1:0]   sc_field;

  always_comb begin
    sc_state_d = sc_state_q;
    sc_sr_d    = sc_sr_q;
    sc_cnt_d   = sc_cnt_q;
    sc_field   = '0;
    unique case (sc_state_q)
      StIdle: begin
        if (sc_load_i) begin
          sc_sr_d    = sc_word_i;
          sc_cnt_d   = KW'(CHUNKS);
          sc_state_d = StShift;
        end
      end
      StShift: begin
        if (frame_en_i) begin
          sc_field = sc_sr_q[SC_LEN-1 -: SC_W];
          sc_sr_d  = sc_sr_q << SC_W;
          sc_cnt_d = sc_cnt_q - 1'b1;
          if (sc_cnt_q == KW'(1)) sc_state_d = StIdle;
        end
      end
      default: sc_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sc_state_q <= StIdle;
      sc_sr_q    <= '0;
      sc_cnt_q   <= '0;
    end else begin
      sc_state_q <= sc_state_d;
      sc_sr_q    <= sc_sr_d;
      sc_cnt_q   <= sc_cnt_d;
    end
  end

  assign sc_busy_o = (sc_state_q == StShift);

  // Registered frame outputs
  logic [FW-1:0] frame_q;
  logic          frame_valid_q;
  logic [PW-1:0] page_out_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      frame_q       <= '0;
      frame_valid_q <= 1'b0;
      page_out_q    <= '0;
    end else begin
      frame_valid_q <= frame_en_i;
      if (frame_en_i) begin
        frame_q    <= {sc_field, mot_field, mem_field};
        page_out_q <= page_q;
      end
    end
  end

  assign frame_o       = frame_q;
  assign frame_valid_o = frame_valid_q;
  assign page_o        = page_out_q;

endmodule

// File: tb/tb_sfp_stream_frame_mux.sv
// Self-checking bench for sfp_stream_frame_mux: directed scenarios plus random traffic,
// compared against a queue-based reference model.
module tb_sfp_stream_frame_mux;

  localparam int SC_W      = 4;
  localparam int MOT_W     = 16;
  localparam int SLOTS     = 4;
  localparam int N_MOT     = 16;
  localparam int MEM_W     = 16;
  localparam int MEM_DEPTH = 8;
  localparam int SC_LEN    = 32;
  localparam int PAGES     = N_MOT / SLOTS;
  localparam int CHUNKS    = SC_LEN / SC_W;
  localparam int FW        = SC_W + SLOTS * MOT_W + MEM_W;
  localparam logic [MEM_W-1:0] IDLE_WORD = 16'hBEEF;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic                   frame_en = 1'b0;
  logic [N_MOT*MOT_W-1:0] motor = '0;
  logic [MEM_W-1:0]       mem_data = '0;
  logic                   mem_valid = 1'b0;
  logic                   mem_ready;
  logic [SC_LEN-1:0]      sc_word = '0;
  logic                   sc_load = 1'b0;
  logic                   sc_busy;
  logic [FW-1:0]          frame;
  logic                   frame_valid;
  logic [1:0]             page;

  sfp_stream_frame_mux #(
    .SC_W(SC_W), .MOT_W(MOT_W), .SLOTS(SLOTS), .N_MOT(N_MOT), .MEM_W(MEM_W),
    .MEM_DEPTH(MEM_DEPTH), .SC_LEN(SC_LEN), .MEM_IDLE(IDLE_WORD)
  ) dut (
    .clk          (clk),
    .reset        (rst),
    .frame_en_i   (frame_en),
    .motor_i      (motor),
    .mem_data_i   (mem_data),
    .mem_valid_i  (mem_valid),
    .mem_ready_o  (mem_ready),
    .sc_word_i    (sc_word),
    .sc_load_i    (sc_load),
    .sc_busy_o    (sc_busy),
    .frame_o      (frame),
    .frame_valid_o(frame_valid),
    .page_o       (page)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model state
  logic [MEM_W-1:0] m_fifo[$];
  logic [SC_W-1:0]  m_chunks[$];
  logic [MOT_W-1:0] m_snap[N_MOT];
  int               m_page = 0;
  logic [FW-1:0]    exp_frame = '0;
  logic             exp_valid = 1'b0;
  int               exp_page = 0;

  // Advance model by one clock using current inputs, then clock DUT and compare.
  task automatic step();
    logic                   pre_busy;
    logic                   do_push;
    logic [SC_W-1:0]        scf;
    logic [SLOTS*MOT_W-1:0] mf;
    logic [MEM_W-1:0]       mm;
    if (rst) begin
      m_fifo.delete();
      m_chunks.delete();
      m_page    = 0;
      exp_frame = '0;
      exp_valid = 1'b0;
      exp_page  = 0;
    end else begin
      pre_busy  = (m_chunks.size() > 0);
      do_push   = mem_valid && (m_fifo.size() < MEM_DEPTH);
      exp_valid = frame_en;
      if (frame_en) begin
        for (int s = 0; s < SLOTS; s++) begin
          if (m_page == 0) mf[s*MOT_W +: MOT_W] = motor[s*MOT_W +: MOT_W];
          else mf[s*MOT_W +: MOT_W] = m_snap[m_page*SLOTS + s];
        end
        if (m_page == 0)
          for (int k = 0; k < N_MOT; k++) m_snap[k] = motor[k*MOT_W +: MOT_W];
        mm = IDLE_WORD;
        if (m_fifo.size() > 0) mm = m_fifo.pop_front();
        scf = '0;
        if (pre_busy) scf = m_chunks.pop_front();
        exp_frame = {scf, mf, mm};
        exp_page  = m_page;
        m_page    = (m_page + 1) % PAGES;
      end
      if (do_push) m_fifo.push_back(mem_data);
      if (sc_load && !pre_busy)
        for (int i = 0; i < CHUNKS; i++) m_chunks.push_back(sc_word[SC_LEN-1-i*SC_W -: SC_W]);
    end
    @(posedge clk);
    #1;
    check("frame", frame, exp_frame);
    check("valid", frame_valid, exp_valid);
    check("page", page, exp_page);
    check("busy", sc_busy, m_chunks.size() > 0);
    check("ready", mem_ready, !rst && (m_fifo.size() < MEM_DEPTH));
  endtask

  task automatic strobe();
    frame_en = 1'b1;
    step();
    frame_en = 1'b0;
  endtask

  logic [31:0] pat;

  initial begin
    // 1: reset then three empty frames
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();
    for (int i = 0; i < 3; i++) begin
      strobe();
      check("t1_page", page, i);
      check("t1_sc", frame[FW-1 -: SC_W], 0);
      check("t1_mem", frame[MEM_W-1:0], IDLE_WORD);
      step();
    end

    // 2: coherent motor sweep
    strobe();
    for (int k = 0; k < N_MOT; k++) motor[k*MOT_W +: MOT_W] = 16'h1000 + 16'(k);
    strobe();
    for (int s = 0; s < SLOTS; s++) check("t2_p0", frame[MEM_W + s*MOT_W +: MOT_W], 16'h1000 + s);
    for (int k = 0; k < N_MOT; k++) motor[k*MOT_W +: MOT_W] = 16'hFFFF;
    for (int p = 1; p < PAGES; p++) begin
      strobe();
      for (int s = 0; s < SLOTS; s++)
        check("t2_slot", frame[MEM_W + s*MOT_W +: MOT_W], 16'h1000 + p*SLOTS + s);
    end
    strobe();
    check("t2_page0", page, 0);
    for (int s = 0; s < SLOTS; s++) check("t2_new", frame[MEM_W + s*MOT_W +: MOT_W], 16'hFFFF);

    // 3: FIFO fill, stall, drain
    mem_valid = 1'b1;
    for (int i = 0; i < 9; i++) begin
      mem_data = 16'h0100 + 16'(i);
      check("t3_ready", mem_ready, i < MEM_DEPTH);
      step();
    end
    strobe();
    check("t3_mem", frame[MEM_W-1:0], 16'h0100);
    step();
    mem_valid = 1'b0;
    for (int i = 1; i < 9; i++) begin
      strobe();
      check("t3_mem", frame[MEM_W-1:0], 16'h0100 + i);
    end
    strobe();
    check("t3_idle", frame[MEM_W-1:0], IDLE_WORD);

    // 4: SC serialisation, load during busy ignored
    pat = 32'hA5C3_0F1E;
    sc_word = pat;
    sc_load = 1'b1;
    step();
    sc_load = 1'b0;
    check("t4_busy", sc_busy, 1);
    for (int i = 0; i < CHUNKS; i++) begin
      if (i == 3) begin
        sc_word = 32'hFFFF_FFFF;
        sc_load = 1'b1;
        step();
        sc_load = 1'b0;
      end
      strobe();
      check("t4_sc", frame[FW-1 -: SC_W], pat[31-4*i -: 4]);
      check("t4_busy", sc_busy, i < CHUNKS - 1);
    end
    strobe();
    check("t4_after", frame[FW-1 -: SC_W], 0);

    // 5: reset mid-operation
    sc_word = pat;
    sc_load = 1'b1;
    step();
    sc_load = 1'b0;
    strobe();
    strobe();
    mem_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      mem_data = 16'h0200 + 16'(i);
      step();
    end
    mem_valid = 1'b0;
    rst = 1'b1;
    step();
    check("t5_frame", frame, 0);
    check("t5_busy", sc_busy, 0);
    check("t5_ready", mem_ready, 0);
    step();
    rst = 1'b0;
    step();
    strobe();
    check("t5_sc", frame[FW-1 -: SC_W], 0);
    check("t5_mem", frame[MEM_W-1:0], IDLE_WORD);
    check("t5_page", page, 0);

    // 6: load coincident with strobe
    sc_word = pat;
    sc_load = 1'b1;
    frame_en = 1'b1;
    step();
    sc_load = 1'b0;
    frame_en = 1'b0;
    check("t6_sc0", frame[FW-1 -: SC_W], 0);
    strobe();
    check("t6_scA", frame[FW-1 -: SC_W], 4'hA);

    // Random traffic
    for (int c = 0; c < 600; c++) begin
      frame_en  = ($urandom_range(0, 2) == 0);
      mem_valid = ($urandom_range(0, 1) == 1);
      mem_data  = 16'($urandom);
      sc_load   = ($urandom_range(0, 7) == 0);
      sc_word   = $urandom;
      rst       = ($urandom_range(0, 149) == 0);
      for (int k = 0; k < N_MOT; k++) motor[k*MOT_W +: MOT_W] = 16'($urandom);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
